// File: rtl/sha1_wb_feeder.sv
// sha1_wb_feeder: Wishbone classic initiator that writes a 512-bit message
// block into the SHA-1 accelerator as 16 word writes, then reads back the
// five digest words. A per-transfer wait counter aborts the job with a sticky
// error if the slave never acknowledges.
module sha1_wb_feeder #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [31:0] DIGEST_ADDR = 32'h3000_0040,
  parameter logic [15:0] TIMEOUT     = 16'd255
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         start,
  input  logic [511:0] block_i,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic [31:0]  wbm_dat_i,
  input  logic         wbm_ack_i,
  output logic [159:0] digest_o,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_GAP = 3'd2,
    RD_REQ = 3'd3,
    RD_GAP = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Word 0 of the block sits in the most significant bits.
  function automatic logic [31:0] block_word(input logic [511:0] blk, input logic [3:0] idx);
    block_word = 32'h0000_0000;
    for (int i = 0; i < 16; i++) begin
      if (idx == i[3:0]) begin
        block_word = blk[511 - 32*i -: 32];
      end
    end
  endfunction

  // Replace digest word idx (word 0 = most significant) with val.
  function automatic logic [159:0] put_digest_word(input logic [159:0] dig, input logic [3:0] idx,
                                                   input logic [31:0] val);
    put_digest_word = dig;
    for (int j = 0; j < 5; j++) begin
      if (idx == j[3:0]) begin
        put_digest_word[159 - 32*j -: 32] = val;
      end
    end
  endfunction

  state_t         state_r, state_s;
  logic [511:0]   buf_r, buf_s;
  logic [3:0]     cnt_r, cnt_s;
  logic [15:0]    wait_r, wait_s;
  logic           cyc_r, cyc_s;
  logic           stb_r, stb_s;
  logic           we_r, we_s;
  logic [3:0]     sel_r, sel_s;
  logic [31:0]    adr_r, adr_s;
  logic [31:0]    dat_r, dat_s;
  logic [159:0]   digest_r, digest_s;
  logic           busy_r, busy_s;
  logic           done_r, done_s;
  logic           error_r, error_s;
  logic           wait_expired_s;

  // A REQ cycle without ack that would bring the wait count to TIMEOUT ends the job.
  assign wait_expired_s = (wait_r == (TIMEOUT - 16'd1));

  // Next-state, counters and next output values; bus outputs are decoded from the next state.
  always_comb begin
    state_s  = state_r;
    buf_s    = buf_r;
    cnt_s    = cnt_r;
    wait_s   = wait_r;
    digest_s = digest_r;
    error_s  = error_r;
    cyc_s    = 1'b0;
    stb_s    = 1'b0;
    we_s     = 1'b0;
    sel_s    = 4'b0000;
    adr_s    = adr_r;
    dat_s    = dat_r;
    done_s   = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          buf_s   = block_i;
          error_s = 1'b0;
          cnt_s   = 4'd0;
          wait_s  = 16'd0;
          state_s = WR_REQ;
        end else begin
          state_s = IDLE;
        end
      end
      WR_REQ: begin
        // Ack is checked first so a late ack beats the timeout.
        if (wbm_ack_i) begin
          state_s = WR_GAP;
        end else if (wait_expired_s) begin
          error_s = 1'b1;
          state_s = DONE;
        end else begin
          wait_s = wait_r + 16'd1;
        end
      end
      WR_GAP: begin
        wait_s = 16'd0;
        if (cnt_r == 4'd15) begin
          cnt_s   = 4'd0;
          state_s = RD_REQ;
        end else begin
          cnt_s   = cnt_r + 4'd1;
          state_s = WR_REQ;
        end
      end
      RD_REQ: begin
        if (wbm_ack_i) begin
          digest_s = put_digest_word(digest_r, cnt_r, wbm_dat_i);
          state_s  = RD_GAP;
        end else if (wait_expired_s) begin
          error_s = 1'b1;
          state_s = DONE;
        end else begin
          wait_s = wait_r + 16'd1;
        end
      end
      RD_GAP: begin
        wait_s = 16'd0;
        if (cnt_r == 4'd4) begin
          state_s = DONE;
        end else begin
          cnt_s   = cnt_r + 4'd1;
          state_s = RD_REQ;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    case (state_s)
      WR_REQ: begin
        cyc_s = 1'b1;
        stb_s = 1'b1;
        we_s  = 1'b1;
        sel_s = 4'b1111;
        adr_s = BASE_ADDR + {26'd0, cnt_s, 2'b00};
        dat_s = block_word(buf_s, cnt_s);
      end
      RD_REQ: begin
        cyc_s = 1'b1;
        stb_s = 1'b1;
        adr_s = DIGEST_ADDR + {26'd0, cnt_s, 2'b00};
      end
      DONE: begin
        done_s = 1'b1;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r  <= IDLE;
      buf_r    <= 512'd0;
      cnt_r    <= 4'd0;
      wait_r   <= 16'd0;
      cyc_r    <= 1'b0;
      stb_r    <= 1'b0;
      we_r     <= 1'b0;
      sel_r    <= 4'b0000;
      adr_r    <= 32'h0000_0000;
      dat_r    <= 32'h0000_0000;
      digest_r <= 160'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      buf_r    <= buf_s;
      cnt_r    <= cnt_s;
      wait_r   <= wait_s;
      cyc_r    <= cyc_s;
      stb_r    <= stb_s;
      we_r     <= we_s;
      sel_r    <= sel_s;
      adr_r    <= adr_s;
      dat_r    <= dat_s;
      digest_r <= digest_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      error_r  <= error_s;
    end
  end

  assign wbm_cyc_o = cyc_r;
  assign wbm_stb_o = stb_r;
  assign wbm_we_o  = we_r;
  assign wbm_sel_o = sel_r;
  assign wbm_adr_o = adr_r;
  assign wbm_dat_o = dat_r;
  assign digest_o  = digest_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;

endmodule

// File: tb/tb_sha1_wb_feeder.sv
// Directed bench for sha1_wb_feeder with a behavioural Wishbone slave and a
// transfer scoreboard (expected bus transfers queued at start, popped on ack).
module tb_sha1_wb_feeder;

  localparam logic [31:0]  BASE = 32'h3000_0000;
  localparam logic [31:0]  DIG  = 32'h3000_0040;
  localparam logic [159:0] ABC_DIGEST =
    {32'hA9993E36, 32'h4706816A, 32'hBA3E2571, 32'h7850C26C, 32'h9CD0D89D};
  localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'd0, 32'h00000018};

  typedef logic [68:0] xfer_t;  // {we, sel, adr, wdata}

  logic         clk = 1'b0;
  logic         wb_rst_i = 1'b1;
  logic         start = 1'b0;
  logic [511:0] block_i = 512'd0;
  logic         wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]   wbm_sel_o;
  logic [31:0]  wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic         wbm_ack_i;
  logic [159:0] digest_o;
  logic         busy, done, error;

  int n_assert = 0;
  int n_fail   = 0;
  xfer_t exp_q[$];

  // slave controls
  logic ws_en = 1'b0, hang_en = 1'b0, spur_en = 1'b0;
  logic s_ack;
  int   s_wcnt;
  int   s_extra;
  logic s_hang;
  logic [31:0] dig_words [5] = '{32'hA9993E36, 32'h4706816A, 32'hBA3E2571, 32'h7850C26C, 32'h9CD0D89D};

  sha1_wb_feeder #(.BASE_ADDR(BASE), .DIGEST_ADDR(DIG), .TIMEOUT(16'd20)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (wb_rst_i),
    .start    (start),
    .block_i  (block_i),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i),
    .digest_o (digest_o),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave: decode per-address wait states / hang and read data.
  always_comb begin
    s_extra   = 0;
    s_hang    = 1'b0;
    wbm_dat_i = 32'h0;
    if (ws_en && ((wbm_we_o && wbm_adr_o == BASE + 32'd28) || (!wbm_we_o && wbm_adr_o == DIG + 32'd8)))
      s_extra = 3;
    if (hang_en && wbm_we_o && wbm_adr_o == BASE + 32'd16)
      s_hang = 1'b1;
    for (int j = 0; j < 5; j++)
      if (!wbm_we_o && wbm_adr_o == DIG + 32'(4 * j)) wbm_dat_i = dig_words[j];
  end

  // Slave: registered ack one cycle after stb plus optional extra waits.
  always @(posedge clk) begin
    if (wb_rst_i || !(wbm_cyc_o && wbm_stb_o) || s_ack) begin
      s_ack  <= 1'b0;
      s_wcnt <= 0;
    end else if (!s_hang) begin
      if (s_wcnt >= s_extra) s_ack <= 1'b1;
      else s_wcnt <= s_wcnt + 1;
    end
  end

  assign wbm_ack_i = s_ack | (spur_en & ~wbm_stb_o);

  // Monitor: hold-stability during waits and scoreboard pop on each accepted transfer.
  logic  prev_hold = 1'b0;
  xfer_t prev_x = '0;
  always @(negedge clk) begin
    xfer_t cur;
    cur = {wbm_we_o, wbm_sel_o, wbm_adr_o, (wbm_we_o ? wbm_dat_o : 32'h0)};
    if (!wb_rst_i && wbm_cyc_o && wbm_stb_o) begin
      if (prev_hold) check("hold_stable", 192'(cur), 192'(prev_x));
      if (wbm_ack_i) begin
        if (exp_q.size() == 0) check("unexpected_xfer", 192'(cur), 192'd0);
        else check("xfer", 192'(cur), 192'(exp_q.pop_front()));
      end
    end
    prev_hold <= !wb_rst_i && wbm_cyc_o && wbm_stb_o && !wbm_ack_i;
    prev_x    <= cur;
  end

  task automatic push_expected(input logic [511:0] blk, input int nwr, input int nrd);
    for (int i = 0; i < nwr; i++)
      exp_q.push_back({1'b1, 4'b1111, BASE + 32'(4 * i), blk[511 - 32*i -: 32]});
    for (int j = 0; j < nrd; j++)
      exp_q.push_back({1'b0, 4'b0000, DIG + 32'(4 * j), 32'h0});
  endtask

  // One job: start sampled at edge 0; n counts cycles (cycle n follows edge n-1).
  task automatic run(input logic [511:0] blk, input logic [511:0] alt, input int restart_cyc,
                     input int rst_cyc, output int done_cyc, output int last_stb, output logic err_c1);
    int n;
    n = 0; done_cyc = -1; last_stb = -1; err_c1 = 1'bx;
    @(negedge clk);
    block_i = blk;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (n < 150 && done_cyc < 0) begin
      @(negedge clk);
      n++;
      if (n == 1) err_c1 = error;
      if (wbm_stb_o) last_stb = n;
      if (done) done_cyc = n;
      if (n == restart_cyc) begin
        start = 1'b1;
        block_i = alt;
      end else begin
        start = 1'b0;
      end
      if (n == rst_cyc) wb_rst_i = 1'b1;
      if (n == rst_cyc + 1) begin
        check("rst_bus", 192'({wbm_cyc_o, wbm_stb_o}), 192'd0);
        check("rst_status", 192'({busy, done, error}), 192'd0);
        check("rst_digest", 192'(digest_o), 192'd0);
      end
      if (n == rst_cyc + 2) wb_rst_i = 1'b0;
      if (rst_cyc > 0 && n == rst_cyc + 20) break;
    end
  endtask

  initial begin
    int dc, ls;
    logic e1;
    logic [511:0] alt;
    for (int i = 0; i < 16; i++) alt[511 - 32*i -: 32] = $urandom;

    // reset values
    repeat (3) @(negedge clk);
    check("reset_bus", 192'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}), 192'd0);
    check("reset_status", 192'({digest_o, busy, done, error}), 192'd0);
    wb_rst_i = 1'b0;
    @(negedge clk);

    // 1: "abc" block, zero-wait slave
    push_expected(ABC_BLOCK, 16, 5);
    run(ABC_BLOCK, alt, -10, -10, dc, ls, e1);
    check("t1_done_cycle", 192'(dc), 192'(64));
    check("t1_digest", 192'(digest_o), 192'(ABC_DIGEST));
    check("t1_error", 192'(error), 192'd0);
    check("t1_sb_empty", 192'(exp_q.size()), 192'd0);
    @(negedge clk);
    check("t1_after", 192'({done, busy}), 192'd0);

    // 2: start re-pulsed in cycle 10 with a different block is ignored
    push_expected(ABC_BLOCK, 16, 5);
    run(ABC_BLOCK, alt, 10, -10, dc, ls, e1);
    check("t2_done_cycle", 192'(dc), 192'(64));
    check("t2_digest", 192'(digest_o), 192'(ABC_DIGEST));
    check("t2_sb_empty", 192'(exp_q.size()), 192'd0);
    @(negedge clk);
    check("t2_no_restart", 192'({busy, wbm_cyc_o}), 192'd0);

    // 3: three wait states on write 7 and read 2
    ws_en = 1'b1;
    push_expected(alt, 16, 5);
    run(alt, ABC_BLOCK, -10, -10, dc, ls, e1);
    check("t3_done_cycle", 192'(dc), 192'(70));
    check("t3_digest", 192'(digest_o), 192'(ABC_DIGEST));
    check("t3_sb_empty", 192'(exp_q.size()), 192'd0);
    ws_en = 1'b0;
    @(negedge clk);

    // 4: spurious acks in every gap cycle
    spur_en = 1'b1;
    push_expected(ABC_BLOCK, 16, 5);
    run(ABC_BLOCK, alt, -10, -10, dc, ls, e1);
    check("t4_done_cycle", 192'(dc), 192'(64));
    check("t4_digest", 192'(digest_o), 192'(ABC_DIGEST));
    check("t4_sb_empty", 192'(exp_q.size()), 192'd0);
    spur_en = 1'b0;
    @(negedge clk);

    // 5: write 4 never acked, TIMEOUT = 20
    hang_en = 1'b1;
    push_expected(alt, 4, 0);
    run(alt, ABC_BLOCK, -10, -10, dc, ls, e1);
    check("t5_done_cycle", 192'(dc), 192'(33));
    check("t5_last_stb", 192'(ls), 192'(32));
    check("t5_error", 192'({error, wbm_cyc_o, wbm_stb_o}), 192'(3'b100));
    check("t5_digest_kept", 192'(digest_o), 192'(ABC_DIGEST));
    check("t5_sb_empty", 192'(exp_q.size()), 192'd0);
    @(negedge clk);
    check("t5_after", 192'({busy, done, error}), 192'(3'b001));
    hang_en = 1'b0;

    // 6: next start clears error and completes cleanly
    push_expected(ABC_BLOCK, 16, 5);
    run(ABC_BLOCK, alt, -10, -10, dc, ls, e1);
    check("t6_error_cleared", 192'(e1), 192'd0);
    check("t6_done_cycle", 192'(dc), 192'(64));
    check("t6_error_end", 192'(error), 192'd0);
    @(negedge clk);

    // 7: reset asserted in cycle 30, then a clean run
    push_expected(alt, 16, 5);
    run(alt, ABC_BLOCK, -10, 30, dc, ls, e1);
    check("t7_no_done", 192'(dc), 192'(-1));
    check("t7_idle", 192'({busy, wbm_cyc_o, digest_o}), 192'd0);
    exp_q.delete();
    push_expected(ABC_BLOCK, 16, 5);
    run(ABC_BLOCK, alt, -10, -10, dc, ls, e1);
    check("t7_done_cycle", 192'(dc), 192'(64));
    check("t7_digest", 192'(digest_o), 192'(ABC_DIGEST));
    check("t7_sb_empty", 192'(exp_q.size()), 192'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sha1_wb_feeder.md
Name: sha1_wb_feeder

Overview:
- Wishbone classic initiator that drives the SHA-1 accelerator's Wishbone slave port.
- On `start` it latches a 512-bit message block and writes it as 16 full-word writes.
- It then performs 5 reads to collect the 160-bit digest and presents the result with a `done` pulse.
- Used as an on-chip test/driver in place of firmware; a per-transfer timeout guards against a stalled slave.

Parameters:
- BASE_ADDR, 32'h3000_0000, byte address of the first block word; block word i goes to BASE_ADDR + 4*i.
- DIGEST_ADDR, 32'h3000_0040, byte address of the first digest word; digest word j comes from DIGEST_ADDR + 4*j.
- TIMEOUT, 255, maximum number of cycles to wait for ack with stb high (1..65535).

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- start  in  1  request a transfer; sampled only in IDLE
- block_i  in  512  message block; word 0 = block_i[511:480], word 15 = block_i[31:0]
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  strobe
- wbm_we_o  out  1  1 = write
- wbm_sel_o  out  4  byte lanes
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  slave acknowledge
- digest_o  out  160  digest; word 0 = [159:128]
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  sticky timeout flag; cleared on the next accepted start

Behaviour:
- Reset values: cyc/stb/we = 0, sel = 0, adr = 0, dat_o = 0, digest_o = 0, busy = 0, done = 0, error = 0, state = IDLE.
- All outputs are registered.
- States: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE.
- IDLE:
  - start = 1 → latch block_i into an internal buffer, clear error, word counter = 0, go to WR_REQ.
  - start while not IDLE is ignored; block_i changes after the latch are ignored.
- WR_REQ:
  - cyc = stb = we = 1, sel = 4'b1111.
  - adr = BASE_ADDR + 4*cnt, dat_o = buffer word cnt.
  - Outputs are held stable until ack is sampled high.
  - On ack → WR_GAP.
- WR_GAP:
  - Exactly one cycle with cyc = stb = 0, so the slave's single-cycle ack cannot be re-triggered.
  - cnt == 15 → cnt = 0, go to RD_REQ; else cnt + 1, go to WR_REQ.
- RD_REQ:
  - cyc = stb = 1, we = 0, sel = 4'b0000 (the slave requires a zero mask on digest reads).
  - adr = DIGEST_ADDR + 4*cnt.
  - On ack: capture wbm_dat_i into digest word cnt, go to RD_GAP.
- RD_GAP:
  - One idle cycle.
  - cnt == 4 → DONE; else cnt + 1, go to RD_REQ.
- DONE: done = 1 for one cycle → IDLE; busy drops in the same cycle done falls.
- Timing: with a 1-cycle ack latency each word takes 3 cycles.
  - Start is sampled at edge 0; the first stb is visible in cycle 1.
  - done is high in cycle 64.
- Ack handling:
  - ack while stb = 0 (gap or IDLE) is ignored.
  - ack in the same cycle stb first rises is accepted (zero-wait slave).
- Timeout:
  - A wait counter clears on entry to each REQ state and increments each REQ cycle without ack.
  - On reaching TIMEOUT: cyc = stb = 0, error = 1, pulse done, return to IDLE.
  - digest_o keeps any words already captured.
  - An ack arriving in the same cycle as the timeout wins: the transfer completes normally.
- Reset mid-operation: cyc/stb drop on the reset edge, all state returns to reset values, and no done pulse is emitted.
- digest_o updates word by word during reads; it is only valid when done = 1 and error = 0.

Test Plan:
- Zero-wait slave model (ack 1 cycle after stb), block = 512'h61626380_000…_00000018 ("abc" padded), slave digest words A9993E36, 4706816A, BA3E2571, 7850C26C, 9CD0D89D → 16 writes at 3000_0000..3000_003C with sel F; 5 reads at 3000_0040..3000_0050 with sel 0; digest_o = 160'hA9993E36…9CD0D89D; done in cycle 64; error = 0.
- Slave with 3 wait states on write 7 and read 2 → stb, adr, dat_o held constant during the waits; done delayed by exactly 6 cycles (cycle 70).
- Slave never acks write 4, TIMEOUT = 20 → stb drops after 20 REQ cycles; error = 1; done pulses; busy = 0 next cycle; next start clears error.
- start pulsed again in cycle 10 with a different block_i → ignored; bus data still equals the first latched block.
- wb_rst_i asserted in cycle 30 (mid-write) → cyc = stb = 0 on that edge; no done pulse; digest_o = 0; a subsequent start runs a full clean transfer.
- Spurious ack during each WR_GAP/RD_GAP cycle → no counter advance; same transfer sequence and result as the first test.
